// File: rtl/stream_demux_4x_nbit_if.sv
// Handshake bundle for the 1-to-4 stream demux: one input stream, four output channels (a..d).
interface stream_demux_4x_nbit_if #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [BUS_WIDTH-1:0] in_data;
  logic [1:0]           in_sel;
  logic                 in_valid;
  logic                 in_ready;

  logic [BUS_WIDTH-1:0] a_data, b_data, c_data, d_data;
  logic                 a_valid, b_valid, c_valid, d_valid;
  logic                 a_ready, b_ready, c_ready, d_ready;
  logic [CNT_WIDTH-1:0] a_cnt, b_cnt, c_cnt, d_cnt;

  // Producer/consumer side (drives the input stream and the channel readies).
  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  a_data, b_data, c_data, d_data,
    input  a_valid, b_valid, c_valid, d_valid,
    output a_ready, b_ready, c_ready, d_ready,
    input  a_cnt, b_cnt, c_cnt, d_cnt
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output a_data, b_data, c_data, d_data,
    output a_valid, b_valid, c_valid, d_valid,
    input  a_ready, b_ready, c_ready, d_ready,
    output a_cnt, b_cnt, c_cnt, d_cnt
  );
endinterface

// File: rtl/stream_demux_4x_nbit.sv
// 1-to-4 valid/ready stream demux with a 1-entry registered buffer per channel.
// Optional per-channel beat counters are built only when DEMUX_CNT_EN is defined.
module stream_demux_4x_nbit #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic                    clk,
  input logic                    reset,
  stream_demux_4x_nbit_if.slave  bus
);
  localparam int unsigned NUM_CH = 4;

  logic [BUS_WIDTH-1:0] data_q [NUM_CH];
  logic [NUM_CH-1:0]    valid_q;
  logic [NUM_CH-1:0]    ready_vec;
  logic [NUM_CH-1:0]    load_vec;
  logic                 in_ready_c;
  logic                 accept_c;

  // Selected buffer accepts when empty or draining this very cycle.
  always_comb begin
    ready_vec  = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
    load_vec   = '0;
    in_ready_c = ~valid_q[bus.in_sel] | ready_vec[bus.in_sel];
    accept_c   = bus.in_valid & in_ready_c;
    load_vec[bus.in_sel] = accept_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_vec[i]) begin
          data_q[i]  <= bus.in_data;
          valid_q[i] <= 1'b1;
        end else if (ready_vec[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.a_data   = data_q[0];
  assign bus.b_data   = data_q[1];
  assign bus.c_data   = data_q[2];
  assign bus.d_data   = data_q[3];
  assign bus.a_valid  = valid_q[0];
  assign bus.b_valid  = valid_q[1];
  assign bus.c_valid  = valid_q[2];
  assign bus.d_valid  = valid_q[3];

`ifdef DEMUX_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];

  // Free-running wrap on overflow; no saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_vec[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.a_cnt = cnt_q[0];
  assign bus.b_cnt = cnt_q[1];
  assign bus.c_cnt = cnt_q[2];
  assign bus.d_cnt = cnt_q[3];
`else
  assign bus.a_cnt = {CNT_WIDTH{1'b0}};
  assign bus.b_cnt = {CNT_WIDTH{1'b0}};
  assign bus.c_cnt = {CNT_WIDTH{1'b0}};
  assign bus.d_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule
